// File: rtl/golden_nonce_queue.sv
`default_nettype none
// ============================================================================
// Module   : golden_nonce_queue
// Brief    : Small FIFO of golden nonces drained one at a time into the serial
//            transmitter through a send/busy handshake; counts overflow drops.
// Revision : 1.0 - initial release
// ============================================================================
module golden_nonce_queue #(
    parameter int DEPTH_LOG2 = 2,
    parameter int WORD_W     = 32
) (
    input  logic              hash_clk,
    input  logic              reset_n,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_nonce,
    input  logic              tx_busy,
    output logic              tx_send,
    output logic [WORD_W-1:0] tx_word,
    output logic              full,
    output logic              empty,
    output logic [7:0]        drop_count
);

    localparam int                      c_cnt_w   = DEPTH_LOG2 + 1;
    localparam int                      c_entries = 1 << DEPTH_LOG2;
    localparam logic [c_cnt_w-1:0]      c_depth   = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [c_cnt_w-1:0]      c_cnt_one = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2-1:0]   c_ptr_one = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    logic [WORD_W-1:0]     mem_q [c_entries];
    logic [DEPTH_LOG2-1:0] wr_ptr_q;
    logic [DEPTH_LOG2-1:0] rd_ptr_q;
    logic [c_cnt_w-1:0]    count_q;
    logic [c_cnt_w-1:0]    count_d;
    logic                  full_q;
    logic                  empty_q;
    logic [7:0]            drop_q;
    state_t                state_q;
    logic                  tx_send_q;
    logic [WORD_W-1:0]     tx_word_q;

    logic pop_d;
    logic push_d;
    logic drop_d;

    // A pop frees a slot in the same cycle, so a push into a full FIFO is
    // accepted whenever the FSM is popping.
    assign pop_d  = (state_q == ST_IDLE) && !empty_q && !tx_busy;
    assign push_d = in_valid && (!full_q || pop_d);
    assign drop_d = in_valid && full_q && !pop_d;

    always_comb begin
        count_d = count_q;
        if (push_d && !pop_d) begin
            count_d = count_q + c_cnt_one;
        end else if (!push_d && pop_d) begin
            count_d = count_q - c_cnt_one;
        end
    end

    always_ff @(posedge hash_clk) begin
        if (push_d) begin
            mem_q[wr_ptr_q] <= in_nonce;
        end
    end

    always_ff @(posedge hash_clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            drop_q   <= 8'd0;
        end else begin
            if (push_d) begin
                wr_ptr_q <= wr_ptr_q + c_ptr_one;
            end
            if (pop_d) begin
                rd_ptr_q <= rd_ptr_q + c_ptr_one;
            end
            count_q <= count_d;
            full_q  <= (count_d == c_depth);
            empty_q <= (count_d == '0);
            if (drop_d && (drop_q != 8'hFF)) begin
                drop_q <= drop_q + 8'd1;
            end
        end
    end

    always_ff @(posedge hash_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            tx_send_q <= 1'b0;
            tx_word_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pop_d) begin
                        tx_word_q <= mem_q[rd_ptr_q];
                        tx_send_q <= 1'b1;
                        state_q   <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (tx_busy) begin
                        tx_send_q <= 1'b0;
                        state_q   <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    tx_send_q <= 1'b0;
                    if (!tx_busy) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    tx_send_q <= 1'b0;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx_send    = tx_send_q;
    assign tx_word    = tx_word_q;
    assign full       = full_q;
    assign empty      = empty_q;
    assign drop_count = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_golden_nonce_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_golden_nonce_queue
// Brief    : Directed bench for golden_nonce_queue with a transmitter model and
//            an expected-word scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_golden_nonce_queue;

    localparam int DEPTH_LOG2 = 2;
    localparam int WORD_W     = 32;
    localparam int BUSY_LEN   = 20;

    logic              hash_clk = 1'b0;
    logic              reset_n;
    logic              in_valid;
    logic [WORD_W-1:0] in_nonce;
    logic              tx_busy;
    logic              tx_send;
    logic [WORD_W-1:0] tx_word;
    logic              full;
    logic              empty;
    logic [7:0]        drop_count;

    logic hold_busy;
    logic model_en;
    logic m_busy;
    logic pend;
    logic in_xfer;
    int   busy_cnt;
    int   sends;
    int   checks;
    int   failures;

    logic [WORD_W-1:0] sb [$];

    assign tx_busy = m_busy | hold_busy;

    golden_nonce_queue #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .WORD_W     (WORD_W)
    ) dut (
        .hash_clk   (hash_clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_nonce   (in_nonce),
        .tx_busy    (tx_busy),
        .tx_send    (tx_send),
        .tx_word    (tx_word),
        .full       (full),
        .empty      (empty),
        .drop_count (drop_count)
    );

    always #5 hash_clk = ~hash_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Transmitter: busy rises one cycle after a new send request is seen and
    // stays high for BUSY_LEN cycles.
    always @(negedge hash_clk) begin
        if (!reset_n) begin
            m_busy   = 1'b0;
            busy_cnt = 0;
            pend     = 1'b0;
            in_xfer  = 1'b0;
        end else begin
            if (busy_cnt == BUSY_LEN) chk("send_fall", {31'd0, tx_send}, 32'd0);
            if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) begin
                    m_busy  = 1'b0;
                    in_xfer = 1'b0;
                end
            end
            if (pend) begin
                pend     = 1'b0;
                m_busy   = 1'b1;
                busy_cnt = BUSY_LEN;
            end
            if (model_en && tx_send && !in_xfer) begin
                in_xfer = 1'b1;
                pend    = 1'b1;
                sends++;
                chk("send_expected", {31'd0, (sb.size() != 0)}, 32'd1);
                if (sb.size() != 0) chk("send_word", tx_word, sb.pop_front());
            end
        end
    end

    task automatic push(input logic [WORD_W-1:0] w, input bit expect_sent);
        in_valid = 1'b1;
        in_nonce = w;
        if (expect_sent) sb.push_back(w);
        @(negedge hash_clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge hash_clk);
            if (sb.size() == 0 && !in_xfer && !pend && empty && !tx_send && !tx_busy) done = 1'b1;
        end
        chk("drain_timeout", {31'd0, done}, 32'd1);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge hash_clk);
        sb.delete();
        reset_n = 1'b1;
        @(negedge hash_clk);
    endtask

    initial begin
        int  base;
        bit  stray;
        checks    = 0;
        failures  = 0;
        sends     = 0;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_nonce  = '0;
        hold_busy = 1'b0;
        model_en  = 1'b1;
        repeat (3) @(negedge hash_clk);
        chk("rst_tx_send", {31'd0, tx_send}, 32'd0);
        chk("rst_tx_word", tx_word, 32'd0);
        chk("rst_full", {31'd0, full}, 32'd0);
        chk("rst_empty", {31'd0, empty}, 32'd1);
        chk("rst_drop", {24'd0, drop_count}, 32'd0);
        reset_n = 1'b1;
        repeat (7) @(negedge hash_clk);

        // Single nonce: send request two cycles after the strobe.
        push(32'h01D0_0F5E, 1'b1);
        chk("single_empty_n1", {31'd0, empty}, 32'd0);
        chk("single_send_n1", {31'd0, tx_send}, 32'd0);
        @(negedge hash_clk);
        chk("single_send_n2", {31'd0, tx_send}, 32'd1);
        chk("single_word_n2", tx_word, 32'h01D0_0F5E);
        chk("single_empty_n2", {31'd0, empty}, 32'd1);
        wait_idle();

        // Burst into a blocked transmitter: four stored, two dropped.
        hold_busy = 1'b1;
        for (int i = 0; i < 4; i++) push(32'h10 + i, 1'b1);
        chk("burst_full", {31'd0, full}, 32'd1);
        push(32'h14, 1'b0);
        push(32'h15, 1'b0);
        chk("burst_drop", {24'd0, drop_count}, 32'd2);
        hold_busy = 1'b0;
        wait_idle();
        chk("burst_drop_hold", {24'd0, drop_count}, 32'd2);

        // Push into a full FIFO in the same cycle the FSM pops.
        do_reset();
        hold_busy = 1'b1;
        for (int i = 0; i < 4; i++) push(32'hA0 + i, 1'b1);
        hold_busy = 1'b0;
        push(32'hA4, 1'b1);
        chk("samepop_drop", {24'd0, drop_count}, 32'd0);
        chk("samepop_full", {31'd0, full}, 32'd1);
        wait_idle();
        chk("samepop_drop_end", {24'd0, drop_count}, 32'd0);

        // Drop counter saturation.
        do_reset();
        hold_busy = 1'b1;
        for (int i = 0; i < 4; i++) push(32'hC0 + i, 1'b0);
        in_valid = 1'b1;
        in_nonce = 32'hDEAD;
        repeat (300) @(negedge hash_clk);
        in_valid = 1'b0;
        chk("sat_drop", {24'd0, drop_count}, 32'd255);
        repeat (5) @(negedge hash_clk);
        chk("sat_drop_hold", {24'd0, drop_count}, 32'd255);
        chk("sat_full", {31'd0, full}, 32'd1);

        // Reset while a send is pending with two entries still queued.
        do_reset();
        hold_busy = 1'b0;
        model_en  = 1'b0;
        push(32'h55, 1'b0);
        push(32'h56, 1'b0);
        push(32'h57, 1'b0);
        chk("midrst_pre_send", {31'd0, tx_send}, 32'd1);
        chk("midrst_pre_word", tx_word, 32'h55);
        chk("midrst_pre_empty", {31'd0, empty}, 32'd0);
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_send", {31'd0, tx_send}, 32'd0);
        chk("midrst_word", tx_word, 32'd0);
        chk("midrst_empty", {31'd0, empty}, 32'd1);
        @(negedge hash_clk);
        reset_n  = 1'b1;
        model_en = 1'b1;
        stray    = 1'b0;
        repeat (20) begin
            @(negedge hash_clk);
            if (tx_send) stray = 1'b1;
        end
        chk("midrst_no_send", {31'd0, stray}, 32'd0);
        push(32'h77, 1'b1);
        wait_idle();

        // Pointer wrap: ten nonces one at a time.
        do_reset();
        base = sends;
        for (int i = 0; i < 10; i++) begin
            push(32'h100 + i, 1'b1);
            wait_idle();
        end
        chk("wrap_sends", sends - base, 32'd10);
        chk("wrap_drop", {24'd0, drop_count}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
